// File: rtl/hazard_if.sv
// ---------------------------------------------------------------------------
// hazard_if
//   Bundles the signals between the pipeline and the hazard/stall controller.
//   The pipeline side (master) reports flush/trap requests, the load in EX,
//   the ID source operands, multi-cycle op starts and memory handshake state.
//   The controller side (slave) returns PC hold, per-stage pause/bubble
//   vectors and the two busy flags.
//
//   Pipe vector bit map: ID=NSTAGE-1, EX=NSTAGE-2, MEM=NSTAGE-3,
//   POST=NSTAGE-4.
// ---------------------------------------------------------------------------
interface hazard_if #(
  parameter int NSTAGE = 4,
  parameter int REGW   = 5
);
  // Requests from the pipeline
  logic              ex_jump;
  logic              ex_flush;
  logic              id_flush;
  logic              mem_flush;
  logic              s_exception;
  logic              ex_load;
  logic [REGW-1:0]   ex_rd;
  logic [REGW-1:0]   rs1;
  logic [REGW-1:0]   rs2;
  logic              rs1_used;
  logic              rs2_used;
  logic              ex_mc_start;
  logic              mem_req;
  logic              mem_ready;

  // Controls back to the pipeline
  logic              pc_pause;
  logic [NSTAGE-1:0] pipe_pause;
  logic [NSTAGE-1:0] pipe_bubble;
  logic              mc_busy;
  logic              trap_busy;

  modport master (
    output ex_jump, ex_flush, id_flush, mem_flush, s_exception,
           ex_load, ex_rd, rs1, rs2, rs1_used, rs2_used,
           ex_mc_start, mem_req, mem_ready,
    input  pc_pause, pipe_pause, pipe_bubble, mc_busy, trap_busy
  );

  modport slave (
    input  ex_jump, ex_flush, id_flush, mem_flush, s_exception,
           ex_load, ex_rd, rs1, rs2, rs1_used, rs2_used,
           ex_mc_start, mem_req, mem_ready,
    output pc_pause, pipe_pause, pipe_bubble, mc_busy, trap_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard and stall controller for the in-order core. Drives the
//   pause (hold) and bubble (insert NOP) controls of every pipeline stage
//   register plus the PC hold.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset, clears both counters
//     bus    - hazard_if.slave: requests in, pause/bubble/busy out
//
//   Parameters:
//     NSTAGE      - pipeline stage count (>=4), width of the pipe vectors
//     REGW        - register index width (must match the interface)
//     MC_LAT      - cycles a multi-cycle op occupies EX (>=2)
//     TRAP_CYCLES - extra redirect cycles held after a trap (0..15)
//
//   Outputs are combinational from the two counters and the inputs; exactly
//   one priority row (trap > mem stall > mc stall > EX flush/jump > load-use
//   > ID flush) drives them.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int NSTAGE      = 4,
  parameter int REGW        = 5,
  parameter int MC_LAT      = 4,
  parameter int TRAP_CYCLES = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  bus
);

  localparam int MCW  = $clog2(MC_LAT);
  localparam int S_ID   = NSTAGE - 1;
  localparam int S_EX   = NSTAGE - 2;
  localparam int S_MEM  = NSTAGE - 3;
  localparam int S_POST = NSTAGE - 4;

  localparam logic [REGW-1:0] REG_X0      = '0;
  localparam logic [MCW-1:0]  MC_ONE      = MCW'(1);
  localparam logic [MCW-1:0]  MC_LOAD     = MCW'(MC_LAT - 1);
  localparam logic [3:0]      TRAP_LOAD   = 4'(TRAP_CYCLES);

  logic [MCW-1:0] mc_cnt_q,   mc_cnt_d;
  logic [3:0]     trap_cnt_q, trap_cnt_d;

  logic load_hz;
  logic mem_stall;
  logic mc_stall;
  logic trap_req;
  logic trap;

  // -------------------------------------------------------------------------
  // Hazard conditions
  // -------------------------------------------------------------------------
  // A load to x0 never produces a value worth waiting for, and a source the
  // ID instruction does not read cannot create a dependency.
  assign load_hz = bus.ex_load && (bus.ex_rd != REG_X0) &&
                   ((bus.rs1_used && (bus.rs1 == bus.ex_rd)) ||
                    (bus.rs2_used && (bus.rs2 == bus.ex_rd)));

  assign mem_stall = bus.mem_req && !bus.mem_ready;

  // mc_cnt==1 is the release cycle: EX advances at its closing edge, so no
  // stall there even if ex_mc_start is still asserted.
  assign mc_stall = ((mc_cnt_q == '0) && bus.ex_mc_start) || (mc_cnt_q > MC_ONE);

  assign trap_req = bus.s_exception || bus.mem_flush;
  assign trap     = trap_req || (trap_cnt_q != '0);

  // -------------------------------------------------------------------------
  // Output priority mux
  // -------------------------------------------------------------------------
  // NOTE: every output gets a default before the priority chain so that no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    bus.pc_pause    = 1'b0;
    bus.pipe_pause  = '0;
    bus.pipe_bubble = '0;

    if (trap) begin
      bus.pc_pause           = 1'b1;
      bus.pipe_bubble[S_ID]  = 1'b1;
      bus.pipe_bubble[S_EX]  = 1'b1;
      bus.pipe_bubble[S_MEM] = 1'b1;
    end else if (mem_stall) begin
      bus.pc_pause            = 1'b1;
      bus.pipe_pause[S_ID]    = 1'b1;
      bus.pipe_pause[S_EX]    = 1'b1;
      bus.pipe_pause[S_MEM]   = 1'b1;
      bus.pipe_bubble[S_POST] = 1'b1;
    end else if (mc_stall) begin
      bus.pc_pause           = 1'b1;
      bus.pipe_pause[S_ID]   = 1'b1;
      bus.pipe_pause[S_EX]   = 1'b1;
      bus.pipe_bubble[S_MEM] = 1'b1;
    end else if (bus.ex_flush || bus.ex_jump) begin
      // A resolved jump already redirects the PC, so only an explicit
      // flush holds it.
      bus.pc_pause          = bus.ex_flush;
      bus.pipe_bubble[S_ID] = 1'b1;
      bus.pipe_bubble[S_EX] = 1'b1;
    end else if (load_hz) begin
      bus.pc_pause          = 1'b1;
      bus.pipe_pause[S_ID]  = 1'b1;
      bus.pipe_bubble[S_EX] = 1'b1;
    end else if (bus.id_flush) begin
      bus.pc_pause          = 1'b1;
      bus.pipe_bubble[S_ID] = 1'b1;
    end
  end

  assign bus.mc_busy   = (mc_cnt_q != '0);
  assign bus.trap_busy = (trap_cnt_q != '0);

  // -------------------------------------------------------------------------
  // Counter next-state
  // -------------------------------------------------------------------------
  always_comb begin
    mc_cnt_d = mc_cnt_q;
    if (trap) begin
      mc_cnt_d = '0;                       // trap aborts the op in EX
    end else if (mem_stall) begin
      mc_cnt_d = mc_cnt_q;                 // frozen while MEM is stalled
    end else if ((mc_cnt_q == '0) && bus.ex_mc_start) begin
      mc_cnt_d = MC_LOAD;
    end else if (mc_cnt_q != '0) begin
      mc_cnt_d = mc_cnt_q - MC_ONE;
    end
  end

  always_comb begin
    trap_cnt_d = trap_cnt_q;
    if (trap_req) begin
      trap_cnt_d = TRAP_LOAD;              // a new trap mid-drain restarts it
    end else if (trap_cnt_q != '0) begin
      trap_cnt_d = trap_cnt_q - 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_cnt_q   <= '0;
      trap_cnt_q <= '0;
    end else begin
      mc_cnt_q   <= mc_cnt_d;
      trap_cnt_q <= trap_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Two instances: A (NSTAGE=4, MC_LAT=4, TRAP_CYCLES=2) for the priority
//   table and the multi-cycle/trap sequences; B (NSTAGE=6, TRAP_CYCLES=3)
//   for the wide pipe map and reset-during-trap.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  // Flag order, MSB first:
  // ex_jump ex_flush id_flush mem_flush s_exception ex_load
  // rs1_used rs2_used ex_mc_start mem_req mem_ready
  typedef struct packed {
    logic       ex_jump;
    logic       ex_flush;
    logic       id_flush;
    logic       mem_flush;
    logic       s_exception;
    logic       ex_load;
    logic       rs1_used;
    logic       rs2_used;
    logic       ex_mc_start;
    logic       mem_req;
    logic       mem_ready;
    logic [4:0] ex_rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } vec_in_t;

  typedef struct {
    string      name;
    vec_in_t    in;
    logic       pc;
    logic [3:0] pause;
    logic [3:0] bubble;
  } vec_t;

  localparam logic [10:0] F_JMP  = 11'b100_0000_0000;
  localparam logic [10:0] F_EXF  = 11'b010_0000_0000;
  localparam logic [10:0] F_IDF  = 11'b001_0000_0000;
  localparam logic [10:0] F_MEMF = 11'b000_1000_0000;
  localparam logic [10:0] F_EXC  = 11'b000_0100_0000;
  localparam logic [10:0] F_LD   = 11'b000_0010_0000;
  localparam logic [10:0] F_U1   = 11'b000_0001_0000;
  localparam logic [10:0] F_U2   = 11'b000_0000_1000;
  localparam logic [10:0] F_MC   = 11'b000_0000_0100;
  localparam logic [10:0] F_MREQ = 11'b000_0000_0010;
  localparam logic [10:0] F_MRDY = 11'b000_0000_0001;
  localparam int NVEC = 17;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;
  int   total;
  int   bad;

  hazard_if #(.NSTAGE(4), .REGW(5)) ifa ();
  hazard_if #(.NSTAGE(6), .REGW(5)) ifb ();

  hazard_ctrl #(.NSTAGE(4), .REGW(5), .MC_LAT(4), .TRAP_CYCLES(2)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (ifa.slave)
  );

  hazard_ctrl #(.NSTAGE(6), .REGW(5), .MC_LAT(3), .TRAP_CYCLES(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_in_t v(input logic [10:0] f, input logic [4:0] rd,
                                input logic [4:0] r1, input logic [4:0] r2);
    return vec_in_t'({f, rd, r1, r2});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec_in_t x);
    ifa.ex_jump = x.ex_jump;   ifa.ex_flush = x.ex_flush;   ifa.id_flush = x.id_flush;
    ifa.mem_flush = x.mem_flush; ifa.s_exception = x.s_exception; ifa.ex_load = x.ex_load;
    ifa.rs1_used = x.rs1_used; ifa.rs2_used = x.rs2_used;   ifa.ex_mc_start = x.ex_mc_start;
    ifa.mem_req = x.mem_req;   ifa.mem_ready = x.mem_ready;
    ifa.ex_rd = x.ex_rd;       ifa.rs1 = x.rs1;             ifa.rs2 = x.rs2;
  endtask

  task automatic drive_b(input vec_in_t x);
    ifb.ex_jump = x.ex_jump;   ifb.ex_flush = x.ex_flush;   ifb.id_flush = x.id_flush;
    ifb.mem_flush = x.mem_flush; ifb.s_exception = x.s_exception; ifb.ex_load = x.ex_load;
    ifb.rs1_used = x.rs1_used; ifb.rs2_used = x.rs2_used;   ifb.ex_mc_start = x.ex_mc_start;
    ifb.mem_req = x.mem_req;   ifb.mem_ready = x.mem_ready;
    ifb.ex_rd = x.ex_rd;       ifb.rs1 = x.rs1;             ifb.rs2 = x.rs2;
  endtask

  task automatic chk_a(input string name, input logic pc, input logic [3:0] pause,
                       input logic [3:0] bubble);
    check({name, ".pc"},     32'(ifa.pc_pause),    32'(pc));
    check({name, ".pause"},  32'(ifa.pipe_pause),  32'(pause));
    check({name, ".bubble"}, 32'(ifa.pipe_bubble), 32'(bubble));
  endtask

  // Advance to just after the next rising edge, ready to drive new inputs.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [NVEC];

  initial begin
    total   = 0;
    bad     = 0;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    drive_a(v(11'd0, 5'd0, 5'd0, 5'd0));
    drive_b(v(11'd0, 5'd0, 5'd0, 5'd0));

    vecs[0]  = '{"idle",         v(11'd0, 0, 0, 0),                       1'b0, 4'b0000, 4'b0000};
    vecs[1]  = '{"ld_use_rs2",   v(F_LD|F_U2, 5, 0, 5),                   1'b1, 4'b1000, 4'b0100};
    vecs[2]  = '{"ld_x0",        v(F_LD|F_U2, 0, 0, 0),                   1'b0, 4'b0000, 4'b0000};
    vecs[3]  = '{"ld_rs1_unused",v(F_LD|F_U2, 7, 7, 3),                   1'b0, 4'b0000, 4'b0000};
    vecs[4]  = '{"ld_rs1_used",  v(F_LD|F_U1, 7, 7, 3),                   1'b1, 4'b1000, 4'b0100};
    vecs[5]  = '{"no_load",      v(F_U1|F_U2, 5, 5, 5),                   1'b0, 4'b0000, 4'b0000};
    vecs[6]  = '{"jump",         v(F_JMP, 0, 0, 0),                       1'b0, 4'b0000, 4'b1100};
    vecs[7]  = '{"ex_flush",     v(F_EXF, 0, 0, 0),                       1'b1, 4'b0000, 4'b1100};
    vecs[8]  = '{"id_flush",     v(F_IDF, 0, 0, 0),                       1'b1, 4'b0000, 4'b1000};
    vecs[9]  = '{"jmp_ld_idf",   v(F_JMP|F_IDF|F_LD|F_U1, 3, 3, 0),       1'b0, 4'b0000, 4'b1100};
    vecs[10] = '{"jmp_ld_memf",  v(F_JMP|F_IDF|F_LD|F_U1|F_MEMF, 3, 3, 0),1'b1, 4'b0000, 4'b1110};
    vecs[11] = '{"exception",    v(F_EXC, 0, 0, 0),                       1'b1, 4'b0000, 4'b1110};
    vecs[12] = '{"mem_stall",    v(F_MREQ, 0, 0, 0),                      1'b1, 4'b1110, 4'b0001};
    vecs[13] = '{"mem_ready",    v(F_MREQ|F_MRDY, 0, 0, 0),               1'b0, 4'b0000, 4'b0000};
    vecs[14] = '{"mc_start",     v(F_MC, 0, 0, 0),                        1'b1, 4'b1100, 4'b0010};
    vecs[15] = '{"mem_over_mc",  v(F_MC|F_MREQ, 0, 0, 0),                 1'b1, 4'b1110, 4'b0001};
    vecs[16] = '{"trap_over_mem",v(F_EXC|F_MREQ|F_MC, 0, 0, 0),           1'b1, 4'b0000, 4'b1110};

    // Reset state
    #12;
    chk_a("rst", 1'b0, 4'b0000, 4'b0000);
    check("rst.mc_busy",   32'(ifa.mc_busy),   32'd0);
    check("rst.trap_busy", 32'(ifa.trap_busy), 32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Priority table: each vector lives between a falling edge and the next
    // rising edge, so counter state is never disturbed.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive_a(vecs[i].in);
      #1;
      chk_a(vecs[i].name, vecs[i].pc, vecs[i].pause, vecs[i].bubble);
      drive_a(v(11'd0, 0, 0, 0));
    end
    check("tbl.mc_busy",   32'(ifa.mc_busy),   32'd0);
    check("tbl.trap_busy", 32'(ifa.trap_busy), 32'd0);

    // Multi-cycle op, ex_mc_start held: stall T..T+2, release T+3.
    next_cycle();
    drive_a(v(F_MC, 0, 0, 0)); #1;
    chk_a("mc.T0", 1'b1, 4'b1100, 4'b0010);
    for (int k = 1; k <= 2; k++) begin
      next_cycle(); #1;
      chk_a($sformatf("mc.T%0d", k), 1'b1, 4'b1100, 4'b0010);
      check($sformatf("mc.T%0d.busy", k), 32'(ifa.mc_busy), 32'd1);
    end
    next_cycle(); #1;
    chk_a("mc.T3", 1'b0, 4'b0000, 4'b0000);
    check("mc.T3.busy", 32'(ifa.mc_busy), 32'd1);
    next_cycle();
    drive_a(v(11'd0, 0, 0, 0)); #1;
    check("mc.T4.busy", 32'(ifa.mc_busy), 32'd0);
    chk_a("mc.T4", 1'b0, 4'b0000, 4'b0000);

    // Same op with a two-cycle memory stall at T+1: release moves to T+5.
    next_cycle();
    drive_a(v(F_MC, 0, 0, 0)); #1;
    chk_a("mcm.T0", 1'b1, 4'b1100, 4'b0010);
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      drive_a(v(F_MC|F_MREQ, 0, 0, 0)); #1;
      chk_a($sformatf("mcm.T%0d", k), 1'b1, 4'b1110, 4'b0001);
    end
    for (int k = 3; k <= 4; k++) begin
      next_cycle();
      drive_a(v(F_MC, 0, 0, 0)); #1;
      chk_a($sformatf("mcm.T%0d", k), 1'b1, 4'b1100, 4'b0010);
    end
    next_cycle(); #1;
    chk_a("mcm.T5", 1'b0, 4'b0000, 4'b0000);
    check("mcm.T5.busy", 32'(ifa.mc_busy), 32'd1);
    next_cycle();
    drive_a(v(11'd0, 0, 0, 0)); #1;
    check("mcm.T6.busy", 32'(ifa.mc_busy), 32'd0);

    // Exception at T+1 during the op, TRAP_CYCLES=2: flush T+1..T+3.
    next_cycle();
    drive_a(v(F_MC, 0, 0, 0)); #1;
    chk_a("trp.T0", 1'b1, 4'b1100, 4'b0010);
    next_cycle();
    drive_a(v(F_MC|F_EXC, 0, 0, 0)); #1;
    chk_a("trp.T1", 1'b1, 4'b0000, 4'b1110);
    check("trp.T1.mc_busy", 32'(ifa.mc_busy), 32'd1);
    next_cycle();
    drive_a(v(11'd0, 0, 0, 0)); #1;
    chk_a("trp.T2", 1'b1, 4'b0000, 4'b1110);
    check("trp.T2.mc_busy",   32'(ifa.mc_busy),   32'd0);
    check("trp.T2.trap_busy", 32'(ifa.trap_busy), 32'd1);
    next_cycle(); #1;
    chk_a("trp.T3", 1'b1, 4'b0000, 4'b1110);
    next_cycle(); #1;
    chk_a("trp.T4", 1'b0, 4'b0000, 4'b0000);
    check("trp.T4.trap_busy", 32'(ifa.trap_busy), 32'd0);

    // Instance B, NSTAGE=6: wide pipe map, then reset mid-trap.
    next_cycle();
    drive_b(v(F_MREQ, 0, 0, 0)); #1;
    check("b.mem.pause",  32'(ifb.pipe_pause),  32'b111000);
    check("b.mem.bubble", 32'(ifb.pipe_bubble), 32'b000100);
    check("b.mem.pc",     32'(ifb.pc_pause),    32'd1);
    next_cycle();
    drive_b(v(F_EXC, 0, 0, 0)); #1;
    check("b.exc.bubble", 32'(ifb.pipe_bubble), 32'b111000);
    next_cycle();
    drive_b(v(11'd0, 0, 0, 0)); #1;
    check("b.drain.trap_busy", 32'(ifb.trap_busy),   32'd1);
    check("b.drain.bubble",    32'(ifb.pipe_bubble), 32'b111000);
    rst_n_b = 1'b0;
    #1;
    check("b.rst.trap_busy", 32'(ifb.trap_busy),   32'd0);
    check("b.rst.bubble",    32'(ifb.pipe_bubble), 32'd0);
    check("b.rst.pc",        32'(ifb.pc_pause),    32'd0);
    next_cycle();
    rst_n_b = 1'b1;
    next_cycle(); #1;
    check("b.post.trap_busy", 32'(ifb.trap_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
